// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        FIN
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT  = 4'd9;
    localparam bcd_digit_t BCD_ADJ_THRESH = 4'd8;
    localparam bcd_digit_t BCD_ADJ_SUB    = 4'd3;

    localparam int unsigned DEFAULT_DIGITS = 3;
    localparam int unsigned DEFAULT_BIN_W  = 10;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-digit correction for reverse double-dabble: after a right shift,
// a digit that picked up the 8 weight from the digit above must lose 3.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (bcd_digit_t'(din) >= BCD_ADJ_THRESH) begin
            dout = din - BCD_ADJ_SUB;
        end
    end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Iterative BCD-to-binary converter (reverse double-dabble, one shift per cycle).
// Optional macro BCD_TO_BINARY_SAT_EN makes bin8 saturate instead of truncate.
module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = DEFAULT_DIGITS,
    parameter int unsigned BIN_W  = DEFAULT_BIN_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      result,
    output logic [7:0]            bin8,
    output logic                  err,
    output logic                  ovf
);

    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned WORK_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W  = $clog2(BIN_W + 1);

    state_t              state_q, state_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_pend_q, err_pend_d;
    logic                done_q, done_d;
    logic [BIN_W-1:0]    result_q, result_d;
    logic [7:0]          bin8_q, bin8_d;
    logic                err_q, err_d;
    logic                ovf_q, ovf_d;

    logic [WORK_W-1:0]   shifted;
    logic [BCD_W-1:0]    adj_hi;
    logic [WORK_W-1:0]   work_step;
    logic                bcd_bad;
    logic [BIN_W-1:0]    conv_res;
    logic                conv_ovf;
    logic [7:0]          conv_bin8;

    assign shifted = work_q >> 1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adjust u_adj (
            .din  (shifted[BIN_W + 4*i +: 4]),
            .dout (adj_hi[4*i +: 4])
        );
    end

    assign work_step = {adj_hi, shifted[BIN_W-1:0]};

    always_comb begin
        bcd_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_digit_t'(bcd[4*i +: 4]) > BCD_MAX_DIGIT) begin
                bcd_bad = 1'b1;
            end
        end
    end

    assign conv_res = work_q[BIN_W-1:0];
    assign conv_ovf = conv_res > BIN_W'(255);
`ifdef BCD_TO_BINARY_SAT_EN
    assign conv_bin8 = conv_ovf ? 8'hFF : conv_res[7:0];
`else
    assign conv_bin8 = conv_res[7:0];
`endif

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        err_pend_d = err_pend_q;
        done_d     = 1'b0;
        result_d   = result_q;
        bin8_d     = bin8_q;
        err_d      = err_q;
        ovf_d      = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Bad digits skip the shift loop and report straight from FIN.
                    if (bcd_bad) begin
                        err_pend_d = 1'b1;
                        state_d    = FIN;
                    end else begin
                        err_pend_d = 1'b0;
                        work_d     = {bcd, {BIN_W{1'b0}}};
                        cnt_d      = '0;
                        state_d    = CONV;
                    end
                end
            end
            CONV: begin
                work_d = work_step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (err_pend_q) begin
                    result_d = '0;
                    bin8_d   = '0;
                    err_d    = 1'b1;
                    ovf_d    = 1'b0;
                end else begin
                    result_d = conv_res;
                    bin8_d   = conv_bin8;
                    err_d    = 1'b0;
                    ovf_d    = conv_ovf;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            work_q     <= '0;
            cnt_q      <= '0;
            err_pend_q <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            bin8_q     <= '0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            err_pend_q <= err_pend_d;
            done_q     <= done_d;
            result_q   <= result_d;
            bin8_q     <= bin8_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy   = (state_q == CONV);
    assign done   = done_q;
    assign result = result_q;
    assign bin8   = bin8_q;
    assign err    = err_q;
    assign ovf    = ovf_q;

endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
- Sequential BCD-to-binary converter: accepts DIGITS packed BCD digits and produces the unsigned binary value.
- Uses an iterative reverse double-dabble: shift right once, then subtract 3 from every BCD digit that is >= 8.
- Sits between board switch/keypad BCD entry and the arithmetic datapath. It is the inverse of the team's binary-to-BCD display path.
- Simple start/busy/done handshake; one conversion in flight at a time.

Parameters:
- DIGITS, 3, number of BCD digits on the input.
- BIN_W, 10, binary result width. Must satisfy 2^BIN_W > 10^DIGITS - 1; 10 covers 999.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- bcd  input  4*DIGITS  packed BCD; digit 0 (units) in [3:0], hundreds in [11:8].
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse: result, err and ovf are valid and updated.
- result  output  BIN_W  binary value; held until the next done.
- bin8  output  8  8-bit view of result for the 8-bit datapath.
- err  output  1  set with done when any input digit > 9.
- ovf  output  1  set with done when result > 255.

Behaviour:
- Reset (async assert, any state): state=IDLE; busy=0, done=0, result=0, bin8=0, err=0, ovf=0; iteration counter=0.
- State machine: IDLE, CONV, FIN.
- IDLE: done=0. If start=1 at edge k:
  - Check all digits. If any is > 9: go to FIN with err_next=1, result_next=0; no conversion.
  - Otherwise load work register {bcd, BIN_W'b0}, cnt=0, go to CONV, busy=1.
- CONV: each edge does one shift-right of the full work register by 1, then corrects each digit (if >= 8, subtract 3).
  - cnt increments each edge. When cnt = BIN_W-1, go to FIN.
  - Exactly BIN_W iterations: edges k+1 .. k+BIN_W.
- FIN: one cycle.
  - result <= low BIN_W bits of work register (or 0 if err); bin8 and ovf updated; busy=0.
  - done=1 for that one cycle, then IDLE.
- Latency:
  - Valid input: done is high in the cycle after edge k+BIN_W+1, i.e. k+11 for default parameters.
  - Invalid input: done after edge k+1.
- start while busy or in FIN: ignored, not queued.
- start held high continuously: a new conversion begins on the first IDLE edge after done, with back-to-back throughput of BIN_W+2 cycles.
- bcd changing during CONV has no effect; input is captured at edge k only.
- err and ovf are exclusive: when err=1, ovf=0.
- result, err, ovf and bin8 are stable between done pulses.
- Reset mid-conversion: abort immediately; no done pulse; all outputs return to reset values.

Optional Feature:
- Macro: BCD_TO_BINARY_SAT_EN.
- Defined: bin8 saturates to 8'd255 when result > 255; ovf still reported.
- Undefined: bin8 = result[7:0] (truncation, modulo 256).
- result is unaffected either way.

Decomposition:
- Package bcd_pkg:
  - state enum (IDLE, CONV, FIN).
  - bcd_digit_t (4-bit) typedef.
  - constants BCD_MAX_DIGIT=9, BCD_ADJ_THRESH=8, BCD_ADJ_SUB=3, DEFAULT_DIGITS=3, DEFAULT_BIN_W=10.
- Sub-module bcd_digit_adjust: combinational, 4-bit in/out, applies the >= 8 subtract-3 rule. Instantiated DIGITS times via generate.
- Everything else (FSM, counter, work register, flags) lives in bcd_to_binary_seq.

Test Plan:
- bcd=12'h255, start pulse -> done exactly 11 cycles after the start edge; result=10'd255, bin8=8'd255, err=0, ovf=0, busy high for 10 cycles.
- bcd=12'h999 -> result=10'd999 (10'h3E7), ovf=1, err=0; bin8=8'd255 with SAT_EN, 8'd231 without.
- bcd=12'h000, then bcd=12'h001 back-to-back with start held high -> results 0 then 1; second done exactly 12 cycles after the first.
- bcd=12'h1A3 -> done 1 cycle after start; err=1, result=0, ovf=0; previous result overwritten.
- start pulses during busy while bcd changes to 12'h777; initial bcd=12'h128 -> single done with result=10'd128; extra starts ignored.
- rst asserted asynchronously mid-CONV (cycle 5) -> busy, done, result, flags go to 0 immediately; no done pulse; next start with 12'h042 gives result=10'd42.
